// File: rtl/ext_mem_sequencer.sv
// rtl/ext_mem_sequencer.sv - host command sequencer driving the processor's external load/run/readback strobes
// One command at a time; strobes are decoded from state so reset clears every output immediately.

module ext_mem_sequencer #(
    parameter int RD_LAT = 2,
    parameter int AW     = 9,
    parameter int DW     = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [15:0]   cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          start,
    output logic          start_2,
    output logic          start_3,
    output logic          start_4,
    output logic [AW-1:0] addr_ext,
    output logic          iram_write_ext,
    output logic          dram_write_ext,
    output logic          read_en_ext,
    output logic [DW-1:0] Data_in_ins,
    output logic [DW-1:0] Data_in_dram,
    input  logic [DW-1:0] dram_in
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_RUN,
        S_RUN_CLEAN,
        S_RB_ISSUE,
        S_RB_WAIT,
        S_RB_OUT,
        S_RB_CLEAR,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    LAT_END  = 8'(RD_LAT);

    state_t        state;
    state_t        state_n;
    logic          dram_sel;
    logic [AW-1:0] addr;
    logic [15:0]   cnt;
    logic [7:0]    lat_cnt;
    logic [DW-1:0] ins_q;
    logic [DW-1:0] dram_q;
    logic [DW-1:0] rd_data_q;
    logic          load_fire;

    assign load_fire    = (state == S_LD_A) && wr_valid;
    assign addr_ext     = addr;
    assign rd_data      = rd_data_q;
    // The load word goes out combinationally in LD_A and is held from the register in LD_B.
    assign Data_in_ins  = (load_fire && !dram_sel) ? wr_data : ins_q;
    assign Data_in_dram = (load_fire &&  dram_sel) ? wr_data : dram_q;

    always_comb begin
        state_n        = state;
        cmd_ready      = 1'b0;
        busy           = (state != S_IDLE);
        done           = 1'b0;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        start          = 1'b0;
        start_2        = 1'b0;
        start_3        = 1'b0;
        start_4        = 1'b0;
        iram_write_ext = 1'b0;
        dram_write_ext = 1'b0;
        read_en_ext    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    if (cmd_len == 16'd0)      state_n = S_DONE;
                    else if (cmd_op == 2'b10)  state_n = S_RUN;
                    else if (cmd_op == 2'b11)  state_n = S_RB_ISSUE;
                    else                       state_n = S_LD_A;
                end
            end
            S_LD_A: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    start_2        = !dram_sel;
                    start_3        = dram_sel;
                    iram_write_ext = !dram_sel;
                    dram_write_ext = dram_sel;
                    state_n        = S_LD_B;
                end
            end
            S_LD_B: begin
                start_2 = !dram_sel;
                start_3 = dram_sel;
                state_n = (cnt == 16'd1) ? S_DONE : S_LD_A;
            end
            S_RUN: begin
                start   = 1'b1;
                state_n = (cnt == 16'd1) ? S_RUN_CLEAN : S_RUN;
            end
            S_RUN_CLEAN: begin
                // DRAM-load strobe with write disabled flushes any write enable the core left latched.
                start_3 = 1'b1;
                state_n = S_DONE;
            end
            S_RB_ISSUE: begin
                start_4     = 1'b1;
                read_en_ext = 1'b1;
                state_n     = S_RB_WAIT;
            end
            S_RB_WAIT: begin
                if (lat_cnt == LAT_END) state_n = S_RB_OUT;
            end
            S_RB_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) state_n = (cnt == 16'd1) ? S_RB_CLEAR : S_RB_ISSUE;
            end
            S_RB_CLEAR: begin
                start_4 = 1'b1;
                state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dram_sel  <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
            lat_cnt   <= '0;
            ins_q     <= '0;
            dram_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dram_sel <= cmd_op[0];
                        addr     <= cmd_base;
                        cnt      <= cmd_len;
                    end
                end
                S_LD_A: begin
                    if (wr_valid) begin
                        if (dram_sel) dram_q <= wr_data;
                        else          ins_q  <= wr_data;
                    end
                end
                S_LD_B: begin
                    addr <= addr + ADDR_ONE;
                    cnt  <= cnt - 16'd1;
                end
                S_RUN: cnt <= cnt - 16'd1;
                S_RB_ISSUE: lat_cnt <= 8'd1;
                S_RB_WAIT: begin
                    if (lat_cnt == LAT_END) rd_data_q <= dram_in;
                    else                    lat_cnt   <= lat_cnt + 8'd1;
                end
                S_RB_OUT: begin
                    if (rd_ready) begin
                        addr <= addr + ADDR_ONE;
                        cnt  <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ext_mem_sequencer.md
Name: ext_mem_sequencer

Overview:
- Host-side initiator for the processor's external load/run/readback interface (start, start_2, start_3, start_4, addr_ext, write/read enables, data buses).
- Accepts one command at a time from a host valid/ready channel. Executes it as a correctly timed sequence of strobes: IRAM load, DRAM load, timed run, or DRAM readback.
- Replaces hand-driven testbench stimulus. Sits between a host link (UART/JTAG bridge) and the multicore top level.

Parameters:
- RD_LAT, 2, cycles from the start_4 issue cycle to the cycle dram_in is sampled (address register plus DRAM registered read).
- AW, 9, memory address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  sequencer idle, command accepted when valid&ready
- cmd_op  in  2  00 load IRAM, 01 load DRAM, 10 run, 11 read back DRAM
- cmd_base  in  AW  start address (loads/readback)
- cmd_len  in  16  word count (loads/readback) or run cycles (run)
- wr_valid / wr_ready  in / out  1  host write-data handshake
- wr_data  in  DW  load word
- rd_valid / rd_ready  out / in  1  readback-data handshake
- rd_data  out  DW  readback word
- busy  out  1  high while a command executes
- done  out  1  one-cycle pulse on command completion
- start, start_2, start_3, start_4  out  1  processor run / IRAM load / DRAM load / DRAM read strobes
- addr_ext  out  AW  external address
- iram_write_ext, dram_write_ext, read_en_ext  out  1  external enables
- Data_in_ins, Data_in_dram  out  DW  load data
- dram_in  in  DW  DRAM read data

Behaviour:
- Reset (async, rst_n=0): every output 0. Includes all strobes, enables, buses, done, busy, rd_valid and wr_ready. cmd_ready=1 once rst_n rises. FSM goes to IDLE; counters and address are cleared. Reset mid-command abandons it without a done pulse.
- Strobe exclusivity: at most one of start/start_2/start_3/start_4 is high in any cycle.
- IDLE: cmd_ready=1. On cmd_valid, latch op/base/len, set busy=1, and go to the op state.
  - cmd_len=0 on any op: no strobes, done pulses the next cycle, return to IDLE.
- LOAD (op 00/01), two cycles per word:
  - LD_A: wr_ready=1. On wr_valid, drive for that cycle: start_2 (IRAM) or start_3 (DRAM)=1, addr_ext=addr, matching write_ext=1, matching Data_in=wr_data. Then go to LD_B.
  - LD_B: wr_ready=0. Same start_2/start_3=1, write_ext=0, Data_in held unchanged. This clears the downstream write-enable register while the memory commits the word.
  - After LD_B: addr increments mod 2^AW (511 wraps to 0) and the count decrements. At count 0 pulse done and go to IDLE; otherwise return to LD_A.
  - A host stall in LD_A leaves all strobes low.
- RUN (op 10):
  - start=1 for exactly cmd_len consecutive cycles.
  - Then one CLEAN cycle: start_3=1, dram_write_ext=0, start=0. This clears any latched core write enable.
  - Then done, IDLE.
- READBACK (op 11), one word in flight:
  - RB_ISSUE: one cycle with start_4=1, addr_ext=addr, read_en_ext=1.
  - RB_WAIT: RD_LAT-1 further cycles with start_4=0.
  - Sample dram_in into rd_data on the RD_LAT-th cycle after issue.
  - RB_OUT: rd_valid=1 with rd_data stable until rd_ready. On the handshake, increment addr (wrap) and decrement the count. Next state is RB_ISSUE, or a done pulse and IDLE when the count reaches 0.
  - rd_ready already high on entry to RB_OUT completes that same cycle.
  - After the last word, one cycle of start_4=1 with read_en_ext=0 before done clears the read enable.
- cmd_valid while busy is ignored (cmd_ready=0). wr_valid outside LD_A and rd_ready outside RB_OUT are ignored.
- done and cmd_ready never overlap the first cycle of a new command: a new command is accepted no earlier than the cycle after done.

Test Plan:
- Reset mid-LOAD: assert rst_n=0 during LD_B → all outputs 0 in the same cycle (async), no done; after release cmd_ready=1.
- IRAM load: base=0x005, len=3, words 0xA001/0xA002/0xA003 → start_2 pulses 6 cycles; write_ext high on cycles 1,3,5 at addr 5,6,7; Data_in_ins held across each pair; done one cycle after the last LD_B.
- DRAM wrap load + readback: load base=0x1FF, len=2 (0x1111, 0x2222) → addresses 0x1FF, 0x000. Readback same → rd_data 0x1111 then 0x2222. Holding rd_ready=0 for 5 cycles keeps rd_valid=1 and data stable.
- Run: len=4 → start high exactly 4 cycles, then one cycle start_3=1/dram_write_ext=0, then done; no other strobe overlaps.
- len=0 for each op → no strobes, done pulse 1 cycle after acceptance. cmd_valid during busy → not accepted (cmd_ready=0).
- Readback latency: RD_LAT=2, dram model returning addr-dependent data → first rd_valid 3 cycles after the start_4 issue cycle; sampled value matches the issued address.
